// File: rtl/sram16_ctrl_if.sv
// Processor memory bus between a master and the SRAM controller:
// a sel/ack handshake carrying address, write strobe, byte mask and data.
interface sram16_ctrl_if;
  logic        sel_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  wr_mask_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;

  modport master (
    output sel_i, addr_i, we_i, wr_mask_i, data_i,
    input  data_o, ack_o
  );

  modport slave (
    input  sel_i, addr_i, we_i, wr_mask_i, data_i,
    output data_o, ack_o
  );
endinterface

// File: rtl/sram16_ctrl.sv
// 32-bit bus to 16-bit async SRAM bridge, low half-word first.
// Optional one-word read buffer enabled by SRAM_WORD_BUFFER_EN.
module sram16_ctrl #(
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int WAIT_CYCLES     = 2
) (
  input  logic                       clk,
  input  logic                       reset_i,
  sram16_ctrl_if.slave               bus,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_o,
  input  logic [15:0]                sram_dq_i,
  output logic [15:0]                sram_dq_o,
  output logic                       sram_dq_oe_o,
  output logic                       sram_ce_n_o,
  output logic                       sram_oe_n_o,
  output logic                       sram_we_n_o,
  output logic                       sram_lb_n_o,
  output logic                       sram_ub_n_o
);

  localparam int SAW = SRAM_ADDR_WIDTH;
  localparam int AW  = SAW - 1;
  localparam int CW  = 5;
  localparam logic [CW-1:0] C_STB  = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] C_HOLD = CW'(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_ACK
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          we_q, we_d;
  logic [3:0]    mask_q, mask_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;

`ifdef SRAM_WORD_BUFFER_EN
  logic          bvld_q, bvld_d;
  logic [AW-1:0] baddr_q, baddr_d;
  logic [31:0]   bdata_q, bdata_d;
`endif

  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[31:SAW+1], bus.addr_i[1:0]};

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef SRAM_WORD_BUFFER_EN
      bvld_q  <= 1'b0;
      baddr_q <= '0;
      bdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef SRAM_WORD_BUFFER_EN
      bvld_q  <= bvld_d;
      baddr_q <= baddr_d;
      bdata_q <= bdata_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    we_d    = we_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef SRAM_WORD_BUFFER_EN
    bvld_d  = bvld_q;
    baddr_d = baddr_q;
    bdata_d = bdata_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.sel_i) begin
          waddr_d = bus.addr_i[SAW:2];
          we_d    = bus.we_i;
          mask_d  = bus.wr_mask_i;
          wdata_d = bus.data_i;
          if (!bus.we_i) begin
`ifdef SRAM_WORD_BUFFER_EN
            if (bvld_q && baddr_q == bus.addr_i[SAW:2]) begin
              rdata_d = bdata_q;
              state_d = S_ACK;
            end else begin
              state_d = S_LO;
            end
`else
            state_d = S_LO;
`endif
          end else begin
`ifdef SRAM_WORD_BUFFER_EN
            bvld_d = 1'b0;
`endif
            if (bus.wr_mask_i[1:0] != 2'b00) state_d = S_LO;
            else if (bus.wr_mask_i[3:2] != 2'b00) state_d = S_HI;
            else state_d = S_ACK;
          end
        end
      end
      S_LO, S_HI: begin
        cnt_d = cnt_q + 1'b1;
        // Sample read data on the edge that closes the last strobe cycle
        if (!we_q && cnt_q == C_STB) begin
          if (state_q == S_LO) begin
            rdata_d[15:0] = sram_dq_i;
          end else begin
            rdata_d[31:16] = sram_dq_i;
`ifdef SRAM_WORD_BUFFER_EN
            bvld_d  = 1'b1;
            baddr_d = waddr_q;
            bdata_d = {sram_dq_i, rdata_q[15:0]};
`endif
          end
        end
        if (cnt_q == C_HOLD) begin
          cnt_d = '0;
          if (state_q == S_HI) state_d = S_ACK;
          else if (we_q && mask_q[3:2] == 2'b00) state_d = S_ACK;
          else state_d = S_HI;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic phase, hi, strobe;
  assign phase  = (state_q == S_LO) || (state_q == S_HI);
  assign hi     = (state_q == S_HI);
  assign strobe = phase && cnt_q != '0 && cnt_q <= C_STB;

  assign bus.ack_o    = (state_q == S_ACK);
  assign bus.data_o   = rdata_q;
  assign sram_addr_o  = phase ? {waddr_q, hi} : '0;
  assign sram_ce_n_o  = !phase;
  assign sram_we_n_o  = !(strobe && we_q);
  assign sram_oe_n_o  = !(strobe && !we_q);
  assign sram_dq_oe_o = phase && we_q;

  always_comb begin
    sram_dq_o   = '0;
    sram_lb_n_o = 1'b1;
    sram_ub_n_o = 1'b1;
    if (phase) begin
      if (!we_q) begin
        sram_lb_n_o = 1'b0;
        sram_ub_n_o = 1'b0;
      end else if (hi) begin
        sram_dq_o   = wdata_q[31:16];
        sram_lb_n_o = ~mask_q[2];
        sram_ub_n_o = ~mask_q[3];
      end else begin
        sram_dq_o   = wdata_q[15:0];
        sram_lb_n_o = ~mask_q[0];
        sram_ub_n_o = ~mask_q[1];
      end
    end
  end

endmodule
